// File: rtl/in_synch_line_padder.sv
//==============================================================================
// Module   : in_synch_line_padder
// Purpose  : Pads or truncates AXI4-Stream video lines to LINE_WIDTH beats and
//            injects FLUSH_CYCLES padding beats after each line.
// Options  : IN_SYNCH_LINE_PADDER_STATUS_EN adds short/long/frame counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module in_synch_line_padder #(
  parameter int                          AXIS_TDATA_WIDTH = 32,
  parameter int                          LINE_WIDTH       = 640,
  parameter int                          FLUSH_CYCLES     = 10,
  parameter logic [AXIS_TDATA_WIDTH-1:0] PAD_VALUE        = '0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tpad
`ifdef IN_SYNCH_LINE_PADDER_STATUS_EN
  ,
  output logic [15:0]                 short_line_cnt,
  output logic [15:0]                 long_line_cnt,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int              c_CW       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int              c_FW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(LINE_WIDTH - 1);
  localparam logic [c_FW-1:0] c_FL_LAST  = c_FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  localparam logic [2:0] c_S_WAIT_SOF = 3'd0;
  localparam logic [2:0] c_S_PASS     = 3'd1;
  localparam logic [2:0] c_S_PAD_LINE = 3'd2;
  localparam logic [2:0] c_S_DISCARD  = 3'd3;
  localparam logic [2:0] c_S_FLUSH    = 3'd4;

  localparam logic [2:0] c_S_AFTER_LINE = (FLUSH_CYCLES > 0) ? c_S_FLUSH : c_S_PASS;

  logic [2:0]                  r_state;
  logic [2:0]                  w_nxt_state;
  logic [c_CW-1:0]             r_col;
  logic [c_CW-1:0]             w_col_nxt;
  logic [c_FW-1:0]             r_fcnt;
  logic [c_FW-1:0]             w_fcnt_nxt;
  logic                        r_resync;
  logic                        w_resync_nxt;

  logic                        r_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic                        r_tlast;
  logic                        r_tuser;
  logic                        r_tpad;
  logic                        w_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] w_tdata;
  logic                        w_tlast;
  logic                        w_tuser;
  logic                        w_tpad;

  logic                        w_adv;
  logic                        w_in_hs;
  logic                        w_col_last;
  logic                        w_fl_last;
  logic                        w_discard_resync;

  assign w_adv            = m_axis_tready | ~r_tvalid;
  assign w_in_hs          = s_axis_tvalid & s_axis_tready;
  assign w_col_last       = (r_col == c_COL_LAST);
  assign w_fl_last        = (r_fcnt == c_FL_LAST);
  assign w_discard_resync = r_resync | s_axis_tuser;

  // Ready tracks the output slot in WAIT_SOF too, so an SOF accepted while the
  // last flush beat is still stalled can never be lost.
  always_comb begin
    s_axis_tready = 1'b0;
    case (r_state)
      c_S_WAIT_SOF: s_axis_tready = w_adv;
      c_S_PASS:     s_axis_tready = w_adv;
      c_S_DISCARD:  s_axis_tready = 1'b1;
      default:      s_axis_tready = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_S_WAIT_SOF;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      c_S_WAIT_SOF: begin
        if (w_in_hs && s_axis_tuser) begin
          w_nxt_state = s_axis_tlast ? c_S_PAD_LINE : c_S_PASS;
        end
      end
      c_S_PASS: begin
        if (w_in_hs) begin
          if (w_col_last) begin
            w_nxt_state = s_axis_tlast ? c_S_AFTER_LINE : c_S_DISCARD;
          end else if (s_axis_tlast) begin
            w_nxt_state = c_S_PAD_LINE;
          end
        end
      end
      c_S_PAD_LINE: begin
        if (w_adv && w_col_last) begin
          w_nxt_state = c_S_AFTER_LINE;
        end
      end
      c_S_DISCARD: begin
        if (w_in_hs && s_axis_tlast) begin
          if (FLUSH_CYCLES > 0) begin
            w_nxt_state = c_S_FLUSH;
          end else begin
            w_nxt_state = w_discard_resync ? c_S_WAIT_SOF : c_S_PASS;
          end
        end
      end
      c_S_FLUSH: begin
        if (w_adv && w_fl_last) begin
          w_nxt_state = r_resync ? c_S_WAIT_SOF : c_S_PASS;
        end
      end
      default: w_nxt_state = c_S_WAIT_SOF;
    endcase
  end

  always_comb begin
    w_tvalid     = 1'b0;
    w_tdata      = PAD_VALUE;
    w_tlast      = 1'b0;
    w_tuser      = 1'b0;
    w_tpad       = 1'b0;
    w_col_nxt    = r_col;
    w_fcnt_nxt   = r_fcnt;
    w_resync_nxt = r_resync;
    case (r_state)
      c_S_WAIT_SOF: begin
        if (w_in_hs && s_axis_tuser) begin
          w_tvalid  = 1'b1;
          w_tdata   = s_axis_tdata;
          w_tuser   = 1'b1;
          w_col_nxt = c_CW'(1);
        end
      end
      c_S_PASS: begin
        if (w_in_hs) begin
          w_tvalid = 1'b1;
          w_tdata  = s_axis_tdata;
          w_tuser  = s_axis_tuser;
          if (w_col_last) begin
            w_tlast   = 1'b1;
            w_col_nxt = '0;
          end else begin
            w_col_nxt = r_col + c_CW'(1);
          end
        end
      end
      c_S_PAD_LINE: begin
        if (w_adv) begin
          w_tvalid = 1'b1;
          w_tpad   = 1'b1;
          if (w_col_last) begin
            w_tlast   = 1'b1;
            w_col_nxt = '0;
          end else begin
            w_col_nxt = r_col + c_CW'(1);
          end
        end
      end
      c_S_DISCARD: begin
        // An SOF swallowed here costs the following frame; remember it so we
        // fall back to hunting for the next SOF once this line is drained.
        if (w_in_hs) begin
          if (s_axis_tlast) begin
            w_resync_nxt = (FLUSH_CYCLES > 0) ? w_discard_resync : 1'b0;
          end else if (s_axis_tuser) begin
            w_resync_nxt = 1'b1;
          end
        end
      end
      c_S_FLUSH: begin
        if (w_adv) begin
          w_tvalid = 1'b1;
          w_tpad   = 1'b1;
          if (w_fl_last) begin
            w_fcnt_nxt   = '0;
            w_resync_nxt = 1'b0;
          end else begin
            w_fcnt_nxt = r_fcnt + c_FW'(1);
          end
        end
      end
      default: begin
        w_col_nxt    = '0;
        w_fcnt_nxt   = '0;
        w_resync_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_col    <= '0;
      r_fcnt   <= '0;
      r_resync <= 1'b0;
    end else begin
      r_col    <= w_col_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_resync <= w_resync_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_tpad   <= 1'b0;
    end else if (w_adv) begin
      r_tvalid <= w_tvalid;
      r_tdata  <= w_tdata;
      r_tlast  <= w_tlast;
      r_tuser  <= w_tuser;
      r_tpad   <= w_tpad;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tpad   = r_tpad;

`ifdef IN_SYNCH_LINE_PADDER_STATUS_EN
  logic        w_short_ev;
  logic        w_long_ev;
  logic        w_frame_ev;
  logic [15:0] r_short_cnt;
  logic [15:0] r_long_cnt;
  logic [15:0] r_frame_cnt;

  assign w_short_ev = (r_state == c_S_PASS) && (w_nxt_state == c_S_PAD_LINE);
  assign w_long_ev  = (r_state == c_S_PASS) && (w_nxt_state == c_S_DISCARD);
  assign w_frame_ev = w_adv && w_tvalid && w_tuser;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_short_ev && (r_short_cnt != 16'hFFFF)) r_short_cnt <= r_short_cnt + 16'd1;
      if (w_long_ev && (r_long_cnt != 16'hFFFF))   r_long_cnt  <= r_long_cnt + 16'd1;
      if (w_frame_ev && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign short_line_cnt = r_short_cnt;
  assign long_line_cnt  = r_long_cnt;
  assign frame_cnt      = r_frame_cnt;
`endif

endmodule

`default_nettype wire
